// File: rtl/next_pc_unit.sv
// Fetch-stage next-PC selection with a direct-mapped BTB and 2-bit counters.
// EX resolution drives the redirect and the BTB update. Lookup is combinational on the current pc.
module next_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic            ExValid,
    input  logic            BranchTaken,
    input  logic            Jump,
    input  logic [XLEN-1:0] pc_branch,
    input  logic [XLEN-1:0] pc_jump,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            Mispredict
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        if (c == 2'b11) return 2'b11;
        else            return c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        if (c == 2'b00) return 2'b00;
        else            return c - 2'b01;
    endfunction

    logic [XLEN-1:0] pc_r;
    logic            valid_r  [BTB_ENTRIES];
    logic [TAGW-1:0] tag_r    [BTB_ENTRIES];
    logic [XLEN-1:0] target_r [BTB_ENTRIES];
    logic [1:0]      ctr_r    [BTB_ENTRIES];

    logic [IDX-1:0]  rd_idx_s, wr_idx_s;
    logic [TAGW-1:0] rd_tag_s, wr_tag_s;
    logic            rd_hit_s, wr_hit_s;
    logic            actual_taken_s;
    logic [XLEN-1:0] actual_target_s, redirect_s, next_pc_s;
    logic            upd_en_s;
    logic [XLEN-1:0] upd_target_s;
    logic [1:0]      upd_ctr_s;

    assign pc       = pc_r;
    assign rd_idx_s = pc_r[IDX+1:2];
    assign rd_tag_s = pc_r[XLEN-1:IDX+2];
    assign wr_idx_s = ex_pc[IDX+1:2];
    assign wr_tag_s = ex_pc[XLEN-1:IDX+2];

    // BTB lookup for the current fetch pc (sees pre-update contents)
    always_comb begin
        rd_hit_s    = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
        pred_taken  = 1'b0;
        pred_target = '0;
        if (rd_hit_s) begin
            pred_taken  = ctr_r[rd_idx_s][1];
            pred_target = target_r[rd_idx_s];
        end else begin
            pred_taken  = 1'b0;
            pred_target = '0;
        end
    end

    // EX resolution: actual outcome, mispredict detection and redirect target
    always_comb begin
        actual_taken_s  = Jump | BranchTaken;
        actual_target_s = Jump ? pc_jump : pc_branch;
        Mispredict      = ExValid & ((actual_taken_s != ex_pred_taken) |
                                     (actual_taken_s & (actual_target_s != ex_pred_target)));
        if (actual_taken_s) begin
            redirect_s = actual_target_s;
        end else begin
            redirect_s = ex_pc + XLEN'(3'd4);
        end
    end

    // Next fetch pc priority: redirect, stall, prediction, sequential
    always_comb begin
        next_pc_s = pc_r + XLEN'(3'd4);
        if (Mispredict) begin
            next_pc_s = redirect_s;
        end else if (Stall) begin
            next_pc_s = pc_r;
        end else if (pred_taken) begin
            next_pc_s = pred_target;
        end else begin
            next_pc_s = pc_r + XLEN'(3'd4);
        end
    end

    // BTB write data: allocate on a taken miss, train counter on a hit
    always_comb begin
        wr_hit_s     = valid_r[wr_idx_s] && (tag_r[wr_idx_s] == wr_tag_s);
        upd_en_s     = 1'b0;
        upd_target_s = target_r[wr_idx_s];
        upd_ctr_s    = ctr_r[wr_idx_s];
        if (ExValid) begin
            if (wr_hit_s) begin
                upd_en_s = 1'b1;
                if (actual_taken_s) begin
                    upd_target_s = actual_target_s;
                    upd_ctr_s    = Jump ? 2'b11 : ctr_inc(ctr_r[wr_idx_s]);
                end else begin
                    upd_ctr_s    = ctr_dec(ctr_r[wr_idx_s]);
                end
            end else if (actual_taken_s) begin
                upd_en_s     = 1'b1;
                upd_target_s = actual_target_s;
                upd_ctr_s    = Jump ? 2'b11 : 2'b10;
            end else begin
                upd_en_s = 1'b0;
            end
        end else begin
            upd_en_s = 1'b0;
        end
    end

    // Fetch pc register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_VECTOR;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // BTB storage; updates ignore Stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                ctr_r[i]    <= 2'b00;
            end
        end else if (upd_en_s) begin
            valid_r[wr_idx_s]  <= 1'b1;
            tag_r[wr_idx_s]    <= wr_tag_s;
            target_r[wr_idx_s] <= upd_target_s;
            ctr_r[wr_idx_s]    <= upd_ctr_s;
        end
    end

endmodule
